// File: rtl/simple_circuit_sweeper.sv
// Exhaustive 3-input sweeper: drives each {a,b,c} vector for DWELL cycles and captures {d_in,e_in}. Optional EXP check via SWEEP_CHECK_EN.
// Latency: RUN one cycle after start, busy for 8*DWELL cycles, then a one-cycle DONE. No backpressure: start is ignored until back in IDLE.
module simple_circuit_sweeper #(
  parameter int unsigned DWELL = 5,
  parameter logic [15:0] EXP   = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        d_in,
  input  logic        e_in,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        busy,
  output logic        done,
  output logic        aborted,
  output logic [2:0]  vec_idx,
  output logic [15:0] resp,
  output logic [3:0]  err_cnt,
  output logic        pass
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

  state_t     state;
  logic [7:0] dwell_cnt;
  logic       dwell_last;
  logic [3:0] err_next;

  assign dwell_last = (dwell_cnt == DWELL_LAST);

`ifdef SWEEP_CHECK_EN
  logic [15:0] exp_word;
  logic [1:0]  exp_pair;
  logic        mismatch;

  assign exp_word = EXP;
  assign exp_pair = exp_word[{vec_idx, 1'b0} +: 2];
  assign mismatch = ({d_in, e_in} != exp_pair);
  // Only 8 vectors exist, so saturating at 8 simply caps the count.
  assign err_next = (mismatch && (err_cnt != 4'd8)) ? err_cnt + 4'd1 : err_cnt;
`else
  logic [15:0] unused_exp;

  assign unused_exp = EXP;
  assign err_next   = 4'd0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      dwell_cnt <= 8'd0;
      vec_idx   <= 3'd0;
      {a, b, c} <= 3'b000;
      busy      <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
      resp      <= 16'h0000;
      err_cnt   <= 4'd0;
      pass      <= 1'b0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && !abort) begin
            state     <= S_RUN;
            busy      <= 1'b1;
            vec_idx   <= 3'd0;
            dwell_cnt <= 8'd0;
            {a, b, c} <= 3'b000;
            resp      <= 16'h0000;
            err_cnt   <= 4'd0;
            pass      <= 1'b0;
          end
        end
        S_RUN: begin
          // Abort wins over a same-cycle capture; partial results stay visible.
          if (abort) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            aborted   <= 1'b1;
            vec_idx   <= 3'd0;
            dwell_cnt <= 8'd0;
            {a, b, c} <= 3'b000;
          end else if (dwell_last) begin
            resp[{vec_idx, 1'b0} +: 2] <= {d_in, e_in};
            err_cnt   <= err_next;
            dwell_cnt <= 8'd0;
            if (vec_idx == 3'd7) begin
              state     <= S_DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
              vec_idx   <= 3'd0;
              {a, b, c} <= 3'b000;
              pass      <= (err_next == 4'd0);
            end else begin
              vec_idx   <= vec_idx + 3'd1;
              {a, b, c} <= vec_idx + 3'd1;
            end
          end else begin
            dwell_cnt <= dwell_cnt + 8'd1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_simple_circuit_sweeper.sv
// Directed bench for simple_circuit_sweeper: stub d=a&b, e=~c on three instances (DWELL 5 matching/mismatching EXP, DWELL 2).
// Expectations follow SWEEP_CHECK_EN when the bundle is built with it.
module tb_simple_circuit_sweeper;

`ifdef SWEEP_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  localparam logic [15:0] EXP_A = 16'hB111;
  localparam logic [15:0] EXP_B = 16'hB110;
  localparam logic [15:0] EXP_C = 16'h0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start_a, abort_a, start_c, abort_off;

  logic        a_a, b_a, c_a, busy_a, done_a, aborted_a, pass_a;
  logic [2:0]  idx_a;
  logic [15:0] resp_a;
  logic [3:0]  err_a;
  logic        a_b, b_b, c_b, busy_b, done_b, aborted_b, pass_b;
  logic [2:0]  idx_b;
  logic [15:0] resp_b;
  logic [3:0]  err_b;
  logic        a_c, b_c, c_c, busy_c, done_c, aborted_c, pass_c;
  logic [2:0]  idx_c;
  logic [15:0] resp_c;
  logic [3:0]  err_c;

  simple_circuit_sweeper #(.DWELL(5), .EXP(EXP_A)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort_a),
    .d_in(a_a & b_a), .e_in(~c_a),
    .a(a_a), .b(b_a), .c(c_a), .busy(busy_a), .done(done_a), .aborted(aborted_a),
    .vec_idx(idx_a), .resp(resp_a), .err_cnt(err_a), .pass(pass_a));

  simple_circuit_sweeper #(.DWELL(5), .EXP(EXP_B)) u_b (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort_off),
    .d_in(a_b & b_b), .e_in(~c_b),
    .a(a_b), .b(b_b), .c(c_b), .busy(busy_b), .done(done_b), .aborted(aborted_b),
    .vec_idx(idx_b), .resp(resp_b), .err_cnt(err_b), .pass(pass_b));

  simple_circuit_sweeper #(.DWELL(2), .EXP(EXP_C)) u_c (
    .clk(clk), .rst(rst), .start(start_c), .abort(abort_off),
    .d_in(a_c & b_c), .e_in(~c_c),
    .a(a_c), .b(b_c), .c(c_c), .busy(busy_c), .done(done_c), .aborted(aborted_c),
    .vec_idx(idx_c), .resp(resp_c), .err_cnt(err_c), .pass(pass_c));

  int n_total = 0;
  int n_pass  = 0;

  // Cumulative event counters, sampled mid-cycle.
  int busy_a_n = 0, done_a_n = 0, abrt_a_n = 0, busy_c_n = 0, done_c_n = 0;
  always @(negedge clk) begin
    if (busy_a === 1'b1)    busy_a_n++;
    if (done_a === 1'b1)    done_a_n++;
    if (aborted_a === 1'b1) abrt_a_n++;
    if (busy_c === 1'b1)    busy_c_n++;
    if (done_c === 1'b1)    done_c_n++;
  end

  typedef struct {
    int         cyc;
    logic       busy;
    logic       done;
    logic [2:0] idx;
    logic [2:0] abc;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_done(input bit use_c, input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim && !ok; i++) begin
      step(1);
      if ((use_c ? done_c : done_a) === 1'b1) ok = 1'b1;
    end
  endtask

  // Model of the stub circuit's response word: D=A&B, E=~C per vector.
  function automatic logic [15:0] stub_resp();
    logic [15:0] r;
    logic [2:0]  k;
    r = 16'h0000;
    for (int i = 0; i < 8; i++) begin
      k = 3'(i);
      r[2*i+1] = k[2] & k[1];
      r[2*i]   = ~k[0];
    end
    return r;
  endfunction

  function automatic int mm_count(input logic [15:0] r, input logic [15:0] e);
    int n;
    n = 0;
    for (int i = 0; i < 8; i++) if (r[2*i +: 2] != e[2*i +: 2]) n++;
    return n;
  endfunction

  initial begin
    logic [15:0] exp_resp;
    int  cur, bsnap, dsnap, asnap;
    bit  ok;

    exp_resp  = stub_resp();
    abort_off = 1'b0;
    rst = 1'b1; start_a = 1'b0; abort_a = 1'b0; start_c = 1'b0;

    tbl[0] = '{1,  1'b1, 1'b0, 3'd0, 3'd0};
    tbl[1] = '{5,  1'b1, 1'b0, 3'd0, 3'd0};
    tbl[2] = '{6,  1'b1, 1'b0, 3'd1, 3'd1};
    tbl[3] = '{15, 1'b1, 1'b0, 3'd2, 3'd2};
    tbl[4] = '{16, 1'b1, 1'b0, 3'd3, 3'd3};
    tbl[5] = '{30, 1'b1, 1'b0, 3'd5, 3'd5};
    tbl[6] = '{36, 1'b1, 1'b0, 3'd7, 3'd7};
    tbl[7] = '{40, 1'b1, 1'b0, 3'd7, 3'd7};
    tbl[8] = '{41, 1'b0, 1'b1, 3'd0, 3'd0};
    tbl[9] = '{42, 1'b0, 1'b0, 3'd0, 3'd0};

    step(3);
    chk("rst_abc_a",   {a_a, b_a, c_a}, 0);
    chk("rst_flags_a", {busy_a, done_a, aborted_a, pass_a}, 0);
    chk("rst_idx_a",   idx_a, 0);
    chk("rst_resp_a",  resp_a, 0);
    chk("rst_err_a",   err_a, 0);
    chk("rst_all_c",   {a_c, b_c, c_c, busy_c, done_c, aborted_c, idx_c, resp_c, err_c, pass_c}, 0);
    rst = 1'b0;
    step(2);

    // start together with abort in IDLE stays idle, abort alone does nothing
    start_a = 1'b1; abort_a = 1'b1;
    step(1);
    start_a = 1'b0;
    chk("start_abort_idle_busy", busy_a, 0);
    step(1);
    abort_a = 1'b0;
    chk("abort_idle_no_pulse", aborted_a, 0);
    step(2);

    // Full sweep, table-driven
    bsnap = busy_a_n; dsnap = done_a_n;
    start_a = 1'b1;
    cur = 0;
    for (int i = 0; i < 10; i++) begin
      while (cur < tbl[i].cyc) begin
        step(1);
        cur++;
        start_a = 1'b0;
      end
      chk($sformatf("sweep_busy_c%0d", tbl[i].cyc), busy_a, tbl[i].busy);
      chk($sformatf("sweep_done_c%0d", tbl[i].cyc), done_a, tbl[i].done);
      chk($sformatf("sweep_idx_c%0d", tbl[i].cyc),  idx_a,  tbl[i].idx);
      chk($sformatf("sweep_abc_c%0d", tbl[i].cyc),  {a_a, b_a, c_a}, tbl[i].abc);
      if (tbl[i].done) chk("pass_in_done_a", pass_a, 1);
    end
    step(3);
    chk("sweep_busy_cycles_a", busy_a_n - bsnap, 40);
    chk("sweep_done_pulses_a", done_a_n - dsnap, 1);
    chk("sweep_resp_a", resp_a, exp_resp);
    chk("sweep_err_a",  err_a, 0);
    chk("sweep_pass_a", pass_a, 1);
    chk("sweep_resp_b", resp_b, exp_resp);
    chk("sweep_err_b",  err_b, CHK ? 1 : 0);
    chk("sweep_pass_b", pass_b, CHK ? 0 : 1);

    // Restart clears results; a second start mid-sweep is ignored
    bsnap = busy_a_n; dsnap = done_a_n;
    start_a = 1'b1;
    step(1);
    start_a = 1'b0;
    chk("restart_resp_clr", resp_a, 0);
    chk("restart_pass_clr", pass_a, 0);
    step(11);
    start_a = 1'b1;
    step(1);
    start_a = 1'b0;
    wait_done(1'b0, 100, ok);
    chk("ignore_start_done_seen", ok, 1);
    step(5);
    chk("ignore_start_busy_cycles", busy_a_n - bsnap, 40);
    chk("ignore_start_done_pulses", done_a_n - dsnap, 1);
    chk("ignore_start_resp", resp_a, exp_resp);
    chk("ignore_start_pass", pass_a, 1);

    // Abort while vector 3 is driven
    asnap = abrt_a_n; dsnap = done_a_n;
    start_a = 1'b1;
    step(1);
    start_a = 1'b0;
    step(15);
    chk("abort_pre_idx", idx_a, 3);
    abort_a = 1'b1;
    step(1);
    abort_a = 1'b0;
    chk("abort_pulse",  aborted_a, 1);
    chk("abort_done",   done_a, 0);
    chk("abort_abc",    {a_a, b_a, c_a}, 0);
    chk("abort_busy",   busy_a, 0);
    chk("abort_resp_lo", resp_a[5:0], exp_resp[5:0]);
    chk("abort_resp",   resp_a, exp_resp & 16'h003F);
    chk("abort_err",    err_a, 0);
    chk("abort_pass",   pass_a, 0);
    step(1);
    chk("abort_one_cycle", aborted_a, 0);
    step(40);
    chk("abort_pulse_count", abrt_a_n - asnap, 1);
    chk("abort_no_done", done_a_n - dsnap, 0);

    // Reset while vector 5 is driven, then a clean sweep
    asnap = abrt_a_n;
    start_a = 1'b1;
    step(1);
    start_a = 1'b0;
    step(25);
    chk("rst_mid_pre_idx", idx_a, 5);
    rst = 1'b1;
    step(1);
    chk("rst_mid_outputs", {a_a, b_a, c_a, busy_a, done_a, aborted_a, idx_a, resp_a, err_a, pass_a}, 0);
    rst = 1'b0;
    step(2);
    chk("rst_mid_no_aborted", abrt_a_n - asnap, 0);
    start_a = 1'b1;
    step(1);
    start_a = 1'b0;
    wait_done(1'b0, 100, ok);
    chk("post_rst_done_seen", ok, 1);
    chk("post_rst_resp", resp_a, exp_resp);
    chk("post_rst_pass", pass_a, 1);
    step(5);
    chk("post_rst_hold_resp", resp_a, exp_resp);

    // Short dwell instance with a mismatching EXP
    bsnap = busy_c_n; dsnap = done_c_n;
    start_c = 1'b1;
    step(1);
    start_c = 1'b0;
    wait_done(1'b1, 50, ok);
    chk("c_done_seen", ok, 1);
    chk("c_resp", resp_c, exp_resp);
    chk("c_err",  err_c, CHK ? mm_count(exp_resp, EXP_C) : 0);
    chk("c_pass", pass_c, CHK ? 0 : 1);
    step(3);
    chk("c_busy_cycles", busy_c_n - bsnap, 16);
    chk("c_done_pulses", done_c_n - dsnap, 1);
    chk("c_pass_hold", pass_c, CHK ? 0 : 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
